// File: rtl/sync_fifo_bram.sv
// sync_fifo_bram: single-clock FIFO with a register-array store and binary pointers
// carrying a wrap bit, so full and empty are told apart without a separate counter.
module sync_fifo_bram #(
   parameter int SIZE    = 8,
   parameter int WIDTH   = 8,
   parameter int PTR_LEN = $clog2(SIZE)
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] data_in,
   input  logic             rd_en,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty,
   output logic [PTR_LEN:0] level
);
   logic [WIDTH-1:0] r_mem [SIZE];
   logic [PTR_LEN:0] r_wr_ptr, r_rd_ptr;
   logic             w_wr_ok, w_rd_ok;
   assign empty   = r_wr_ptr == r_rd_ptr;
   assign full    = (r_wr_ptr[PTR_LEN] != r_rd_ptr[PTR_LEN]) &&
                    (r_wr_ptr[PTR_LEN-1:0] == r_rd_ptr[PTR_LEN-1:0]);
   assign level   = r_wr_ptr - r_rd_ptr;
   // Acceptance uses pre-edge flags only, so a same-cycle read never frees room for a write.
   assign w_wr_ok = wr_en && !full;
   assign w_rd_ok = rd_en && !empty;
   always_ff @(posedge clk) begin
      if (srst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         data_out <= '0;
         for (int i = 0; i < SIZE; i++) r_mem[i] <= '0;
      end else begin
         if (w_wr_ok) begin
            r_mem[r_wr_ptr[PTR_LEN-1:0]] <= data_in;
            r_wr_ptr <= r_wr_ptr + (PTR_LEN+1)'(1);
         end
         if (w_rd_ok) begin
            data_out <= r_mem[r_rd_ptr[PTR_LEN-1:0]];
            r_rd_ptr <= r_rd_ptr + (PTR_LEN+1)'(1);
         end
      end
   end
endmodule

// File: tb/tb_sync_fifo_bram.sv
// tb_sync_fifo_bram: vector-table and directed-sequence checks of sync_fifo_bram
// with SIZE=8, WIDTH=8.
module tb_sync_fifo_bram;
   logic       clk = 1'b0;
   logic       srst = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
   logic [7:0] data_in = '0, data_out;
   logic       full, empty;
   logic [3:0] level;
   int         n_checks = 0, n_fail = 0;

   typedef struct {
      logic       srst, wr, rd;
      logic [7:0] din, dout;
      logic       full, empty;
      logic [3:0] lvl;
   } vec_t;
   vec_t vecs[$];

   sync_fifo_bram #(.SIZE(8), .WIDTH(8)) dut (
      .clk(clk), .srst(srst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .data_out(data_out), .full(full), .empty(empty), .level(level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic s, input logic w, input logic r, input logic [7:0] d);
      @(negedge clk);
      srst = s; wr_en = w; rd_en = r; data_in = d;
      @(posedge clk);
      #1;
   endtask

   task automatic exp4(input string tag, input logic [7:0] dout, input logic f,
                       input logic e, input logic [3:0] l);
      chk({tag, ".data_out"}, data_out, dout);
      chk({tag, ".full"}, {7'b0, full}, {7'b0, f});
      chk({tag, ".empty"}, {7'b0, empty}, {7'b0, e});
      chk({tag, ".level"}, {4'b0, level}, {4'b0, l});
   endtask

   function automatic vec_t mk(logic s, logic w, logic r, logic [7:0] d, logic [7:0] o,
                               logic f, logic e, logic [3:0] l);
      vec_t v;
      v.srst = s; v.wr = w; v.rd = r; v.din = d; v.dout = o;
      v.full = f; v.empty = e; v.lvl = l;
      return v;
   endfunction

   initial begin
      // reset with both requests high, fill, dropped 9th write, drain, empty reads
      vecs.push_back(mk(1, 1, 1, 8'hAA, 8'h00, 0, 1, 0));
      vecs.push_back(mk(1, 1, 1, 8'hAA, 8'h00, 0, 1, 0));
      for (int i = 0; i < 8; i++)
         vecs.push_back(mk(0, 1, 0, 8'h11 + 8'(i), 8'h00, i == 7, 0, 4'(i + 1)));
      vecs.push_back(mk(0, 1, 0, 8'hFF, 8'h00, 1, 0, 8));
      for (int i = 0; i < 8; i++)
         vecs.push_back(mk(0, 0, 1, 8'h00, 8'h11 + 8'(i), 0, i == 7, 4'(7 - i)));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(0, 0, 1, 8'h00, 8'h18, 0, 1, 0));

      foreach (vecs[k]) begin
         cyc(vecs[k].srst, vecs[k].wr, vecs[k].rd, vecs[k].din);
         exp4($sformatf("vec%0d", k), vecs[k].dout, vecs[k].full, vecs[k].empty, vecs[k].lvl);
      end

      // three wrap-around passes toggle the pointer MSBs
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0, 8'h20 * 8'(p + 1) + 8'(i));
            exp4($sformatf("wrap%0d_w%0d", p, i), p == 0 ? 8'h18 : 8'h20 * 8'(p) + 8'h07,
                 i == 7, 0, 4'(i + 1));
         end
         for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 8'h00);
            exp4($sformatf("wrap%0d_r%0d", p, i), 8'h20 * 8'(p + 1) + 8'(i), 0, i == 7, 4'(7 - i));
         end
      end

      // simultaneous read/write at level 4
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 8'h80 + 8'(i));
      exp4("pre4", 8'h67, 0, 0, 4);
      for (int i = 0; i < 10; i++) begin
         cyc(0, 1, 1, 8'h84 + 8'(i));
         exp4($sformatf("sim%0d", i), 8'h80 + 8'(i), 0, 0, 4);
      end
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 1, 8'h00);
         exp4($sformatf("simdrain%0d", i), 8'h8A + 8'(i), 0, i == 3, 4'(3 - i));
      end

      // simultaneous at full: read accepted, write dropped
      for (int i = 0; i < 8; i++) cyc(0, 1, 0, 8'h90 + 8'(i));
      exp4("prefull", 8'h8D, 1, 0, 8);
      cyc(0, 1, 1, 8'hEE);
      exp4("simfull", 8'h90, 0, 0, 7);
      for (int i = 0; i < 7; i++) begin
         cyc(0, 0, 1, 8'h00);
         exp4($sformatf("fulldrain%0d", i), 8'h91 + 8'(i), 0, i == 6, 4'(6 - i));
      end

      // simultaneous at empty: write accepted, read ignored
      cyc(0, 1, 1, 8'h55);
      exp4("simempty", 8'h97, 0, 0, 1);
      cyc(0, 0, 1, 8'h00);
      exp4("simempty_rd", 8'h55, 0, 1, 0);

      // reset mid-operation discards contents
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 8'hC0 + 8'(i));
      exp4("pre_rst", 8'h55, 0, 0, 5);
      cyc(1, 1, 0, 8'hDD);
      exp4("midrst", 8'h00, 0, 1, 0);
      cyc(0, 1, 0, 8'hA5);
      exp4("post_rst_w", 8'h00, 0, 0, 1);
      cyc(0, 0, 1, 8'h00);
      exp4("post_rst_r", 8'hA5, 0, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
